// File: rtl/vga_grid_ctrl.sv
// vga_grid_ctrl: write controller for the 16-cell VGA colour grid memory.
// It arbitrates single-cell updates from port A (MCU) and port B (pattern
// engine) and runs a self-sequenced 16-cell clear. It issues at most one
// registered write per cycle. When VBLANK_ONLY is set, writes are held off
// outside vertical blanking so the visible frame never tears.
//
// Handshake: a_ready_o/b_ready_o are combinational. A transfer happens at any
// rising edge where valid & ready are both high. A requester keeps valid, pos
// and color stable until it sees ready, but it may withdraw valid while ready
// is low. At most one ready is high in a cycle.
module vga_grid_ctrl #(
  parameter int VBLANK_ONLY = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       vblank_i,
  input  logic       a_valid_i,
  input  logic [3:0] a_pos_i,
  input  logic [7:0] a_color_i,
  output logic       a_ready_o,
  input  logic       b_valid_i,
  input  logic [3:0] b_pos_i,
  input  logic [7:0] b_color_i,
  output logic       b_ready_o,
  input  logic       clr_start_i,
  input  logic [7:0] clr_color_i,
  output logic       clr_busy_o,
  output logic       wr_en_o,
  output logic [3:0] wr_pos_o,
  output logic [7:0] wr_color_o,
  output logic       state_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] fill_q;
  logic       last_a_q;   // 1: port A was served last, 0: port B
  logic       wr_en_q;
  logic [3:0] wr_pos_q;
  logic [7:0] wr_color_q;

  logic gate;
  logic serve;
  logic grant_a;
  logic grant_b;

  // Write gate and round-robin grant; a clear request pre-empts A/B this cycle.
  always_comb begin
    gate    = (VBLANK_ONLY == 0) || vblank_i;
    serve   = !rst_i && (state_q == S_IDLE) && !clr_start_i && gate;
    grant_a = serve && a_valid_i && (!b_valid_i || !last_a_q);
    grant_b = serve && b_valid_i && (!a_valid_i || last_a_q);
  end

  // Controller FSM: grant service in IDLE, 16-cell fill sequence in CLEAR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      fill_q     <= 8'd0;
      last_a_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_pos_q   <= 4'd0;
      wr_color_q <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_start_i) begin
            state_q <= S_CLEAR;
            cnt_q   <= 4'd0;
            fill_q  <= clr_color_i;
            wr_en_q <= 1'b0;
          end else if (grant_a) begin
            wr_en_q    <= 1'b1;
            wr_pos_q   <= a_pos_i;
            wr_color_q <= a_color_i;
            last_a_q   <= 1'b1;
          end else if (grant_b) begin
            wr_en_q    <= 1'b1;
            wr_pos_q   <= b_pos_i;
            wr_color_q <= b_color_i;
            last_a_q   <= 1'b0;
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          if (gate) begin
            wr_en_q    <= 1'b1;
            wr_pos_q   <= cnt_q;
            wr_color_q <= fill_q;
            // Completion is the write of cell 15; the counter never wraps.
            if (cnt_q == 4'd15) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign a_ready_o  = grant_a;
  assign b_ready_o  = grant_b;
  assign clr_busy_o = (state_q == S_CLEAR);
  assign wr_en_o    = wr_en_q;
  assign wr_pos_o   = wr_pos_q;
  assign wr_color_o = wr_color_q;
  assign state_o    = state_q;

endmodule

// File: doc/vga_grid_ctrl.md
# vga_grid_ctrl

Write controller for the 16-cell VGA colour grid memory. It arbitrates cell-colour updates from two requesters, port A (MCU) and port B (pattern/animation engine), and also runs a self-sequenced "clear all 16 cells" command. It drives one registered write per cycle (`wr_en`, `wr_pos`, `wr_color`) into the grid colour memory. Optionally, writes are held off until vertical blanking so the visible frame never tears.

## Interface
Parameters:
- `VBLANK_ONLY`, default 1: 1 = writes are issued only while `vblank` = 1; 0 = `vblank` is ignored and writes are always allowed.

Ports:
- `clk`, in, 1: single clock, 25 MHz pixel clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `vblank`, in, 1: vertical blanking indicator from the VGA timing block.
- `a_valid`, in, 1: port A request valid.
- `a_pos`, in, 4: port A cell index, `{grid_y, grid_x}`.
- `a_color`, in, 8: port A colour, RRRGGGBB.
- `a_ready`, out, 1: port A accepted this cycle.
- `b_valid`, in, 1: port B request valid.
- `b_pos`, in, 4: port B cell index.
- `b_color`, in, 8: port B colour.
- `b_ready`, out, 1: port B accepted this cycle.
- `clr_start`, in, 1: single-cycle pulse that starts a clear.
- `clr_color`, in, 8: fill colour, sampled when `clr_start` is accepted.
- `clr_busy`, out, 1: high while a clear sequence is running.
- `wr_en`, out, 1: registered write strobe to the grid memory.
- `wr_pos`, out, 4: registered write address.
- `wr_color`, out, 8: registered write data.

## Operation
- `gate` = `(VBLANK_ONLY == 0) | vblank`.
- States:
  - IDLE: serves A/B requests.
  - CLEAR: sequences 16 fill writes.
- IDLE:
  - If `clr_start` = 1: go to CLEAR, set `cnt` = 0, latch `clr_color`. Both ready outputs are 0 that cycle (clear has priority over A/B).
  - Else if `gate` = 1: grant one valid requester.
  - Only one requester valid: it is granted.
  - Both valid: the requester not served last is granted (round-robin on `last_grant`).
- `a_ready` and `b_ready` are combinational and asserted only for the granted port. They are never both high.
- Transfer happens when `valid & ready` at a rising edge. That edge loads `wr_en` = 1, `wr_pos`, `wr_color`, and updates `last_grant`.
- No transfer at an edge: `wr_en` is loaded 0. `wr_pos` and `wr_color` hold their values.
- Requesters hold `valid`, `pos` and `color` stable until `ready`. A deasserted `valid` without `ready` is legal and is simply withdrawn.
- CLEAR:
  - Each edge with `gate` = 1: `wr_en` = 1, `wr_pos` = `cnt`, `wr_color` = latched colour, `cnt` += 1.
  - Edge with `gate` = 0: `wr_en` = 0 and `cnt` holds (the sequence stalls).
  - The edge that writes `cnt` = 15 returns to IDLE; `cnt` does not wrap.
  - `clr_busy` = (state == CLEAR). `a_ready` = `b_ready` = 0 throughout.
  - `clr_start` while in CLEAR is ignored.
- `cnt` is 4 bits. A 5th internal bit is not used; completion is detected from `cnt` == 15 together with a write.

## Timing
- Reset values: state = IDLE, `cnt` = 0, `last_grant` = B (so A wins the first tie), `wr_en` = 0, `wr_pos` = 0, `wr_color` = 0, `clr_busy` = 0, `a_ready` = `b_ready` = 0 during reset.
- Latency: a request accepted at edge k appears on `wr_*` during cycle k+1. `wr_*` change only on the rising edge, so they are stable at the grid memory's falling-edge write.
- Throughput: one write per cycle. Back-to-back grants are allowed.
- A clear with `gate` held at 1 takes 16 consecutive `wr_en` cycles. `clr_busy` is high for exactly 16 cycles, starting the cycle after `clr_start`.
- `gate` falling mid-stream: no `ready` is asserted and no write is issued from the next evaluation onward. Pending valids wait.
- `rst` mid-clear aborts immediately. Remaining cells are left unwritten and `wr_en` = 0 next cycle.
- `clr_start` and `a_valid` in the same IDLE cycle: clear wins and A waits until the clear completes.

## Test plan
- Reset, then `VBLANK_ONLY` = 1, `vblank` = 0, `a_valid` = 1 (pos 5, colour 0xE0) -> `a_ready` stays 0 and `wr_en` stays 0. Raise `vblank` -> `a_ready` = 1 for one cycle, then next cycle `wr_en` = 1, `wr_pos` = 5, `wr_color` = 0xE0.
- `vblank` = 1, A (pos 1, 0x1C) and B (pos 2, 0x03) both held valid -> grants go A, B, A, B. The `wr_*` sequence is 1/0x1C, 2/0x03, and so on, with `wr_en` high every cycle.
- `clr_start` with `clr_color` = 0xFF, `vblank` = 1 -> `clr_busy` is high for 16 cycles and writes go to pos 0..15 with 0xFF. Both ready outputs stay 0. Return to IDLE.
- During a clear, drop `vblank` after pos 7 for 10 cycles -> writes pause with `cnt` held, then resume at pos 8. A `clr_start` pulse inside the clear is ignored.
- Assert `rst` after the pos 3 clear write -> the next cycle has `wr_en` = 0 and `clr_busy` = 0, and all outputs are at reset values.
- `VBLANK_ONLY` = 0, `vblank` = 0, B valid (pos 15, 0x92) -> the write appears in cycle k+1 regardless of `vblank`.
